// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a NUM_ROWS x NUM_COLS key matrix with a
// one-hot column strobe. Row returns are synchronised and debounced. A single
// pressed key is delivered as code = row*NUM_COLS + col.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
//
// Handshake: key_valid/key_code form a valid/ready source. A press is
// transferred on any clk edge where key_valid && key_ready. key_code is stable
// while key_valid is high and not yet accepted. A new press arriving while an
// unaccepted one is pending is dropped, and key_overrun pulses for one cycle.
module keypad_matrix_scanner #(
    parameter int NUM_ROWS     = 4,
    parameter int NUM_COLS     = 3,
    parameter int CLK_DIV      = 12500,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DLY   = 500,
    parameter int REPEAT_RATE  = 100,
    localparam int CODE_W      = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                key_overrun,
    output logic                key_multi,
    output logic [1:0]          dbg_state
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);

    if (NUM_ROWS < 2 || NUM_ROWS > 8 || NUM_COLS < 2 || NUM_COLS > 8 ||
        CLK_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1)
    begin : g_param_check
        $error("keypad_matrix_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [NUM_ROWS-1:0] r_row_m;
    logic [NUM_ROWS-1:0] r_row_s;
    logic [NUM_ROWS-1:0] r_pat;
    logic [NUM_COLS-1:0] r_col;
    logic [COL_W-1:0]    r_col_ptr;
    logic [DB_W-1:0]     r_cnt;
    logic [DB_W-1:0]     r_rel;
    logic                r_held;
    logic                r_multi;
    logic                r_valid;
    logic [CODE_W-1:0]   r_code;
    logic                r_overrun;

    logic                w_tick;
    logic                w_pat_onehot;
    logic                w_db_done;
    logic                w_emit;
    logic                w_accept;
    logic [ROW_W-1:0]    w_row_idx;
    logic [CODE_W-1:0]   w_code;

    function automatic logic f_onehot(input logic [NUM_ROWS-1:0] v);
        return (v != '0) && ((v & (v - NUM_ROWS'(1))) == '0);
    endfunction

    // Scan tick divider: one-cycle tick when the count reaches CLK_DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    // Two-flop synchroniser for the asynchronous row returns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_m <= '0;
            r_row_s <= '0;
        end else begin
            r_row_m <= key_row;
            r_row_s <= r_row_m;
        end
    end

    // Row index of the latched pattern (meaningful only when it is one-hot)
    always_comb begin
        w_row_idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (r_pat[i]) begin
                w_row_idx = ROW_W'(i);
            end
        end
    end

    // The column is frozen outside SCAN, so the live pointer is the latched column
    assign w_code = CODE_W'(w_row_idx) * CODE_W'(NUM_COLS) + CODE_W'(r_col_ptr);

    assign w_pat_onehot = f_onehot(r_pat);
    assign w_db_done    = w_tick && (r_state == ST_DEBOUNCE) && (r_row_s == r_pat) &&
                          (r_cnt == DB_W'(DEBOUNCE_CNT - 1));
    assign w_accept     = r_valid && key_ready;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;
    logic             w_rep_fire;

    // First repeat waits REPEAT_DLY matching ticks, later ones REPEAT_RATE
    assign w_rep_fire = w_tick && (r_state == ST_HELD) && (r_row_s == r_pat) && w_pat_onehot &&
                        (r_rep_cnt == (r_rep_first ? REP_W'(REPEAT_DLY - 1)
                                                   : REP_W'(REPEAT_RATE - 1)));
    assign w_emit     = (w_db_done && w_pat_onehot) || w_rep_fire;
`else
    assign w_emit     = w_db_done && w_pat_onehot;
`endif

    // Scan / debounce / held state machine with column strobe and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_SCAN;
            r_col       <= NUM_COLS'(1);
            r_col_ptr   <= '0;
            r_pat       <= '0;
            r_cnt       <= '0;
            r_rel       <= '0;
            r_held      <= 1'b0;
            r_multi     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_multi <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (r_row_s != '0) begin
                            r_pat   <= r_row_s;
                            r_cnt   <= '0;
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_col     <= {r_col[NUM_COLS-2:0], r_col[NUM_COLS-1]};
                            r_col_ptr <= (r_col_ptr == COL_W'(NUM_COLS - 1)) ? '0
                                                                             : r_col_ptr + COL_W'(1);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (r_row_s != r_pat) begin
                            r_state <= ST_SCAN;
                        end else if (r_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
                            r_state     <= ST_HELD;
                            r_held      <= 1'b1;
                            r_rel       <= '0;
                            r_multi     <= !w_pat_onehot;
`ifdef KEYPAD_REPEAT_EN
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + DB_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (r_row_s == '0) begin
                            if (r_rel == DB_W'(DEBOUNCE_CNT - 1)) begin
                                r_state   <= ST_SCAN;
                                r_held    <= 1'b0;
                                r_col     <= {r_col[NUM_COLS-2:0], r_col[NUM_COLS-1]};
                                r_col_ptr <= (r_col_ptr == COL_W'(NUM_COLS - 1)) ? '0
                                                                                 : r_col_ptr + COL_W'(1);
                            end else begin
                                r_rel <= r_rel + DB_W'(1);
                            end
                        end else begin
                            r_rel <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        if (r_row_s != r_pat) begin
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b1;
                        end else if (w_rep_fire) begin
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b0;
                        end else if (w_pat_onehot) begin
                            r_rep_cnt <= r_rep_cnt + REP_W'(1);
                        end
`endif
                    end
                    default: begin
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    // Output register: load on emit, drop with overrun pulse if still pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_emit) begin
                if (!r_valid || w_accept) begin
                    r_code  <= w_code;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign key_col     = r_col;
    assign key_code    = r_code;
    assign key_valid   = r_valid;
    assign key_held    = r_held;
    assign key_overrun = r_overrun;
    assign key_multi   = r_multi;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed bench for keypad_matrix_scanner with
// NUM_ROWS=4, NUM_COLS=3, CLK_DIV=4, DEBOUNCE_CNT=3. A keypad model drives
// key_row from the pressed key's rows whenever its column is strobed.
module tb_keypad_matrix_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_held;
    logic       key_overrun;
    logic       key_multi;
    logic [1:0] dbg_state;

    logic [1:0] press_col  = 2'd0;
    logic [3:0] press_rows = 4'b0000;

    int n_vec = 0;
    int n_err = 0;

    // running totals from the monitor
    int tot_acc   = 0;
    int tot_multi = 0;
    int tot_ovr   = 0;
    int col_bad   = 0;
    int last_code = -1;

    typedef struct {
        logic [1:0] col;
        logic [3:0] rows;
        int         exp_emits;
        int         exp_code;
        int         exp_multi;
    } vec_t;

    vec_t vecs[6];

    keypad_matrix_scanner #(
        .NUM_ROWS     (4),
        .NUM_COLS     (3),
        .CLK_DIV      (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .key_overrun (key_overrun),
        .key_multi   (key_multi),
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // keypad: the pressed rows appear only while their column is strobed
    assign key_row = key_col[press_col] ? press_rows : 4'b0000;

    // monitor: accepted codes, pulses, one-hot column
    always @(negedge clk) begin
        if (rst) begin
            if (key_valid && key_ready) begin
                tot_acc   = tot_acc + 1;
                last_code = int'(key_code);
            end
            if (key_multi)   tot_multi = tot_multi + 1;
            if (key_overrun) tot_ovr   = tot_ovr + 1;
            if (key_col == 3'b000 || (key_col & (key_col - 3'd1)) != 3'b000) col_bad = col_bad + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_held_low(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (key_held && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(key_held), 0);
    endtask

    initial begin
        int a0, m0, o0;

        vecs[0] = '{2'd1, 4'b0010, 1, 4,  0};
        vecs[1] = '{2'd0, 4'b0010, 1, 3,  0};
        vecs[2] = '{2'd2, 4'b0011, 0, 0,  1};
        vecs[3] = '{2'd0, 4'b0001, 1, 0,  0};
        vecs[4] = '{2'd2, 4'b1000, 1, 11, 0};
        vecs[5] = '{2'd2, 4'b0100, 1, 8,  0};

        // ---- reset values and idle rotation ----
        clks(3);
        check("rst_col",     int'(key_col), 1);
        check("rst_code",    int'(key_code), 0);
        check("rst_valid",   int'(key_valid), 0);
        check("rst_held",    int'(key_held), 0);
        check("rst_overrun", int'(key_overrun), 0);
        check("rst_multi",   int'(key_multi), 0);
        rst = 1'b1;
        clks(3);
        check("idle_col_edge3", int'(key_col), 1);
        clks(1);
        check("idle_col_edge4", int'(key_col), 2);
        clks(4);
        check("idle_col_edge8", int'(key_col), 4);
        clks(4);
        check("idle_col_edge12", int'(key_col), 1);
        clks(24);
        check("idle_valid", int'(key_valid), 0);
        check("idle_held",  int'(key_held), 0);
        check("idle_acc",   tot_acc, 0);
        check("idle_multi", tot_multi, 0);
        check("idle_ovr",   tot_ovr, 0);

        // ---- exact latency from reset with key already down (code 0) ----
        rst = 1'b0;
        press_col  = 2'd0;
        press_rows = 4'b0001;
        clks(2);
        rst = 1'b1;
        a0 = tot_acc;
        clks(15);
        check("lat_valid_edge15", int'(key_valid), 0);
        clks(1);
        check("lat_valid_edge16", int'(key_valid), 1);
        check("lat_code_edge16",  int'(key_code), 0);
        check("lat_held_edge16",  int'(key_held), 1);
        clks(1);
        check("lat_valid_edge17", int'(key_valid), 0);
        check("lat_acc",          tot_acc - a0, 1);

        // release bounce shorter than the debounce window
        press_rows = 4'b0000; clks(8);
        press_rows = 4'b0001; clks(8);
        press_rows = 4'b0000; clks(8);
        press_rows = 4'b0001; clks(12);
        check("relb_held", int'(key_held), 1);
        check("relb_acc",  tot_acc - a0, 1);
        press_rows = 4'b0000;
        wait_held_low("relb_release_timeout");
        check("relb_col_adv", int'(key_col), 2);

        // ---- asynchronous reset while debouncing on column 1 ----
        rst = 1'b0;
        press_col  = 2'd1;
        press_rows = 4'b0010;
        clks(2);
        rst = 1'b1;
        clks(14);
        check("mdb_col_before",   int'(key_col), 2);
        check("mdb_valid_before", int'(key_valid), 0);
        #2;
        rst = 1'b0;
        #1;
        check("mdb_rst_col",   int'(key_col), 1);
        check("mdb_rst_valid", int'(key_valid), 0);
        check("mdb_rst_held",  int'(key_held), 0);
        check("mdb_rst_code",  int'(key_code), 0);
        @(negedge clk);
        rst = 1'b1;
        a0 = tot_acc;
        clks(60);
        check("mdb_acc",  tot_acc - a0, 1);
        check("mdb_code", last_code, 4);
        check("mdb_held", int'(key_held), 1);
        press_rows = 4'b0000;
        wait_held_low("mdb_release_timeout");
        check("mdb_col_adv", int'(key_col), 4);

        // ---- table of single presses and a chord ----
        for (int i = 0; i < 6; i++) begin
            a0 = tot_acc;
            m0 = tot_multi;
            o0 = tot_ovr;
            press_col  = vecs[i].col;
            press_rows = vecs[i].rows;
            clks(60);
            check($sformatf("vec%0d_held_on", i), int'(key_held), 1);
            press_rows = 4'b0000;
            clks(40);
            check($sformatf("vec%0d_held_off", i), int'(key_held), 0);
            check($sformatf("vec%0d_emits", i), tot_acc - a0, vecs[i].exp_emits);
            check($sformatf("vec%0d_multi", i), tot_multi - m0, vecs[i].exp_multi);
            check($sformatf("vec%0d_ovr", i), tot_ovr - o0, 0);
            if (vecs[i].exp_emits > 0)
                check($sformatf("vec%0d_code", i), last_code, vecs[i].exp_code);
        end

        // ---- press bounce on column 0, then a clean press (code 3) ----
        a0 = tot_acc;
        press_col = 2'd0;
        for (int k = 0; k < 5; k++) begin
            press_rows = 4'b0010; clks(6);
            press_rows = 4'b0000; clks(6);
        end
        check("bounce_no_emit", tot_acc - a0, 0);
        check("bounce_no_held", int'(key_held), 0);
        press_rows = 4'b0010;
        clks(60);
        press_rows = 4'b0000;
        clks(40);
        check("bounce_then_emit", tot_acc - a0, 1);
        check("bounce_code",      last_code, 3);

        // ---- overrun: consumer stalled across two presses ----
        key_ready = 1'b0;
        a0 = tot_acc;
        o0 = tot_ovr;
        press_col = 2'd0; press_rows = 4'b0001;
        clks(60);
        press_rows = 4'b0000;
        clks(40);
        check("ovr_valid_first", int'(key_valid), 1);
        check("ovr_code_first",  int'(key_code), 0);
        press_col = 2'd2; press_rows = 4'b1000;
        clks(60);
        press_rows = 4'b0000;
        clks(40);
        check("ovr_valid_kept", int'(key_valid), 1);
        check("ovr_code_kept",  int'(key_code), 0);
        check("ovr_pulses",     tot_ovr - o0, 1);
        key_ready = 1'b1;
        clks(1);
        check("ovr_valid_clr", int'(key_valid), 0);
        check("ovr_code_hold", int'(key_code), 0);
        check("ovr_acc",       tot_acc - a0, 1);

        check("col_onehot_always", col_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
